// File: rtl/temp_pkg.sv
// Shared definitions for the temperature-sensor measurement sequencer:
// sensor controller state codes and the sequencer state encoding.
package temp_pkg;

  // Phase codes reported by the sensor controller on sensor_state.
  localparam logic [1:0] SENSOR_WARMUP = 2'd0;
  localparam logic [1:0] SENSOR_PTAT   = 2'd1;
  localparam logic [1:0] SENSOR_CTAT   = 2'd3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRST = 3'd1,
    ST_WARM = 3'd2,
    ST_MEAS = 3'd3,
    ST_DONE = 3'd4,
    ST_WAIT = 3'd5
  } seq_state_e;

  // True for the two phases in which the sensor controller is running.
  function automatic logic is_sensing(input seq_state_e st);
    return (st == ST_WARM) || (st == ST_MEAS);
  endfunction

endpackage

// File: rtl/temp_seq_capture.sv
// Registers the sensor controller's state and count every cycle and flags
// the end of each PTAT and CTAT phase. At a flagged edge cnt_q holds the
// final count of the phase that just ended.
module temp_seq_capture
  import temp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sensor_state,
  input  logic [7:0] sensor_count,
  output logic [7:0] cnt_q,
  output logic       ptat_stb,
  output logic       ctat_stb
);

  logic [1:0] st_q;

  // Delay sensor state and count by one cycle for phase-change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= SENSOR_WARMUP;
      cnt_q <= 8'd0;
    end else begin
      st_q  <= sensor_state;
      cnt_q <= sensor_count;
    end
  end

  // A PTAT phase ends when the sensor moves on to CTAT, and vice versa.
  assign ptat_stb = (st_q == SENSOR_PTAT) && (sensor_state == SENSOR_CTAT);
  assign ctat_stb = (st_q == SENSOR_CTAT) && (sensor_state == SENSOR_PTAT);

endmodule

// File: rtl/temp_seq.sv
// Temperature measurement sequencer. Resets and warms up the sensor
// controller, accumulates PTAT/CTAT phase lengths, presents the result
// with a valid/ready handshake and optionally repeats periodically.
// Build option: define TEMP_SEQ_AVG_EN to accumulate 2^N_AVG_LOG2 sample
// pairs per result; without it a single pair is captured.
module temp_seq
  import temp_pkg::*;
#(
  parameter int unsigned N_AVG_LOG2  = 2,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  per_en,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [1:0]            sensor_state,
  input  logic [7:0]            sensor_count,
  output logic                  sensor_rst,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8+N_AVG_LOG2-1:0] ptat_sum,
  output logic [8+N_AVG_LOG2-1:0] ctat_sum,
  output logic                  res_err
);

  localparam int unsigned SUM_W  = 8 + N_AVG_LOG2;
  localparam int unsigned PAIR_W = N_AVG_LOG2 + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned WN_W   = PERIOD_W + 1;
`ifdef TEMP_SEQ_AVG_EN
  localparam int unsigned N_PAIRS = 1 << N_AVG_LOG2;
`else
  localparam int unsigned N_PAIRS = 1;
`endif
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(N_PAIRS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  seq_state_e          state_r;
  logic                sensor_rst_r;
  logic                busy_r;
  logic                res_valid_r;
  logic                res_err_r;
  logic [SUM_W-1:0]    ptat_sum_r;
  logic [SUM_W-1:0]    ctat_sum_r;
  logic [PAIR_W-1:0]   pair_cnt_r;
  logic [TMO_W-1:0]    tmo_r;
  logic [PERIOD_W-1:0] wait_cnt_r;
  logic                srst_cnt_r;

  logic [7:0]          cnt_q;
  logic                ptat_stb_s;
  logic                ctat_stb_s;
  logic                acc_ptat_s;
  logic                acc_ctat_s;
  logic                last_pair_s;
  logic                tmo_hit_s;
  logic [WN_W-1:0]     wait_next_s;
  logic                wait_done_s;
  logic                enter_srst_s;

  temp_seq_capture u_capture (
    .clk          (clk),
    .reset        (reset),
    .sensor_state (sensor_state),
    .sensor_count (sensor_count),
    .cnt_q        (cnt_q),
    .ptat_stb     (ptat_stb_s),
    .ctat_stb     (ctat_stb_s)
  );

  // Samples are only taken while measuring; a pair completes on its CTAT sample.
  assign acc_ptat_s  = (state_r == ST_MEAS) && ptat_stb_s;
  assign acc_ctat_s  = (state_r == ST_MEAS) && ctat_stb_s;
  assign last_pair_s = acc_ctat_s && (pair_cnt_r == LAST_PAIR);
  assign tmo_hit_s   = (tmo_r == TMO_LAST);

  // WAIT lasts max(period, 1) cycles; >= keeps it bounded if period shrinks mid-wait.
  assign wait_next_s = {1'b0, wait_cnt_r} + WN_W'(1'b1);
  assign wait_done_s = (wait_next_s >= {1'b0, period});

  // start is only honoured from IDLE, so a pulse while busy is dropped.
  assign enter_srst_s = ((state_r == ST_IDLE) && (start || per_en)) ||
                        ((state_r == ST_WAIT) && per_en && wait_done_s);

  // Accumulate captured phase lengths; a new measurement starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      ptat_sum_r <= '0;
      ctat_sum_r <= '0;
      pair_cnt_r <= '0;
    end else if (enter_srst_s) begin
      ptat_sum_r <= '0;
      ctat_sum_r <= '0;
      pair_cnt_r <= '0;
    end else begin
      if (acc_ptat_s) begin
        ptat_sum_r <= ptat_sum_r + SUM_W'(cnt_q);
      end
      if (acc_ctat_s) begin
        ctat_sum_r <= ctat_sum_r + SUM_W'(cnt_q);
        pair_cnt_r <= pair_cnt_r + PAIR_W'(1'b1);
      end
    end
  end

  // Sequencer state machine with its phase counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      sensor_rst_r <= 1'b1;
      busy_r       <= 1'b0;
      res_valid_r  <= 1'b0;
      res_err_r    <= 1'b0;
      tmo_r        <= '0;
      wait_cnt_r   <= '0;
      srst_cnt_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enter_srst_s) begin
            state_r    <= ST_SRST;
            busy_r     <= 1'b1;
            srst_cnt_r <= 1'b0;
          end
        end
        ST_SRST: begin
          if (srst_cnt_r) begin
            state_r      <= ST_WARM;
            sensor_rst_r <= 1'b0;
            tmo_r        <= '0;
          end else begin
            srst_cnt_r <= 1'b1;
          end
        end
        ST_WARM: begin
          if (sensor_state == SENSOR_PTAT) begin
            state_r <= ST_MEAS;
            tmo_r   <= '0;
          end else if (tmo_hit_s) begin
            state_r      <= ST_DONE;
            sensor_rst_r <= 1'b1;
            res_valid_r  <= 1'b1;
            res_err_r    <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        ST_MEAS: begin
          // A capture restarts the phase timer, so it outranks a timeout in the same cycle.
          if (last_pair_s) begin
            state_r      <= ST_DONE;
            sensor_rst_r <= 1'b1;
            res_valid_r  <= 1'b1;
            res_err_r    <= 1'b0;
          end else if (acc_ptat_s || acc_ctat_s) begin
            tmo_r <= '0;
          end else if (tmo_hit_s) begin
            state_r      <= ST_DONE;
            sensor_rst_r <= 1'b1;
            res_valid_r  <= 1'b1;
            res_err_r    <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            res_err_r   <= 1'b0;
            if (per_en) begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= '0;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!per_en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (enter_srst_s) begin
            state_r    <= ST_SRST;
            srst_cnt_r <= 1'b0;
          end else begin
            wait_cnt_r <= wait_next_s[PERIOD_W-1:0];
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          sensor_rst_r <= 1'b1;
          busy_r       <= 1'b0;
          res_valid_r  <= 1'b0;
          res_err_r    <= 1'b0;
        end
      endcase
    end
  end

  // The sensor controller runs only during WARM and MEAS; this cross-check
  // keeps the registered reset line honest against the state encoding.
  logic sensor_rst_chk_s;
  assign sensor_rst_chk_s = !is_sensing(state_r);

  assign sensor_rst = sensor_rst_r & sensor_rst_chk_s;
  assign busy       = busy_r;
  assign res_valid  = res_valid_r;
  assign res_err    = res_err_r;
  assign ptat_sum   = ptat_sum_r;
  assign ctat_sum   = ctat_sum_r;

endmodule

// File: tb/tb_temp_seq.sv
// Self-checking bench for temp_seq: table-driven measurements, multi-cycle
// corner sequences and randomized phase lengths against a sensor model
// that records the phase lengths it produced.
module tb_temp_seq;

`ifdef TEMP_SEQ_AVG_EN
  localparam int NP = 4;
`else
  localparam int NP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, start, per_en, res_ready;
  logic [15:0] period;
  logic [1:0]  sensor_state = 2'd0;
  logic [7:0]  sensor_count = 8'd0;
  logic        sensor_rst, busy, res_valid, res_err;
  logic [9:0]  ptat_sum, ctat_sum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // sensor model controls and history
  int warm_len = 8;
  int p_fix = 40;
  int c_fix = 60;
  bit rand_len = 1'b0;
  bit stuck = 1'b0;
  int ptat_hist[$];
  int ctat_hist[$];
  int first_ptat_cyc = 0;
  int s_ph = 0, s_cnt = 0, s_len = 0;

  typedef struct {
    int p;
    int c;
    int exp_p;
    int exp_c;
  } vec_t;
  vec_t tbl[4];

  int hs, e, bad;
  bit ok;
  logic [9:0] p0, c0;
  logic err0;

  temp_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .per_en       (per_en),
    .period       (period),
    .sensor_state (sensor_state),
    .sensor_count (sensor_count),
    .sensor_rst   (sensor_rst),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .ptat_sum     (ptat_sum),
    .ctat_sum     (ctat_sum),
    .res_err      (res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sensor controller model: WARMUP, then alternating PTAT/CTAT phases whose
  // count runs 1..length; held in WARMUP while sensor_rst is high.
  always @(negedge clk) begin
    if (sensor_rst !== 1'b0) begin
      s_ph = 0; s_cnt = 0; s_len = warm_len;
    end else if (s_cnt >= s_len && !(stuck && s_ph == 1)) begin
      if (s_ph == 1) begin
        s_ph = 3;
        s_len = rand_len ? int'($urandom_range(2, 120)) : c_fix;
        ctat_hist.push_back(s_len);
      end else begin
        if (s_ph == 0) first_ptat_cyc = cyc;
        s_ph = 1;
        s_len = rand_len ? int'($urandom_range(2, 120)) : p_fix;
        ptat_hist.push_back(s_len);
      end
      s_cnt = 1;
    end else begin
      s_cnt++;
    end
    sensor_state = 2'(s_ph);
    sensor_count = (s_cnt > 255) ? 8'd255 : 8'(s_cnt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (res_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rst_low(input int limit, output int edge_no, output bit found);
    found = 1'b0;
    edge_no = 0;
    for (int i = 0; i < limit; i++) begin
      if (sensor_rst === 1'b0) begin
        found = 1'b1;
        edge_no = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake(output int hs_edge);
    res_ready = 1'b1;
    hs_edge = cyc + 1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic clear_hist();
    ptat_hist.delete();
    ctat_hist.delete();
  endtask

  // Expected result: the sum of the first NP PTAT and CTAT phase lengths.
  task automatic check_model(input string tag);
    int ep, ec;
    ep = 0; ec = 0;
    for (int i = 0; i < NP && i < ptat_hist.size(); i++) ep += ptat_hist[i];
    for (int i = 0; i < NP && i < ctat_hist.size(); i++) ec += ctat_hist[i];
    chk({tag, "_ptat"}, 32'(ptat_sum), 32'(ep));
    chk({tag, "_ctat"}, 32'(ctat_sum), 32'(ec));
    chk({tag, "_err"}, 32'(res_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; per_en = 1'b0; res_ready = 1'b0; period = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_sensor_rst", 32'(sensor_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_ptat", 32'(ptat_sum), 32'd0);
    chk("rst_ctat", 32'(ctat_sum), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // single-shot measurements from a table of fixed phase lengths
    tbl[0] = '{40, 60, NP * 40, NP * 60};
    tbl[1] = '{2, 2, NP * 2, NP * 2};
    tbl[2] = '{255, 255, NP * 255, NP * 255};
    tbl[3] = '{100, 7, NP * 100, NP * 7};
    for (int i = 0; i < 4; i++) begin
      p_fix = tbl[i].p; c_fix = tbl[i].c;
      clear_hist();
      pulse_start();
      chk("tbl_busy", 32'(busy), 32'd1);
      wait_valid(5000, ok);
      chk("tbl_valid", 32'(ok), 32'd1);
      chk("tbl_ptat", 32'(ptat_sum), 32'(tbl[i].exp_p));
      chk("tbl_ctat", 32'(ctat_sum), 32'(tbl[i].exp_c));
      chk("tbl_err", 32'(res_err), 32'd0);
      chk("tbl_sensor_rst", 32'(sensor_rst), 32'd1);
      handshake(hs);
      chk("tbl_idle", 32'(busy), 32'd0);
      chk("tbl_valid_clr", 32'(res_valid), 32'd0);
    end
    p_fix = 40; c_fix = 60;

    // sensor stuck in PTAT: timeout 1000 cycles after MEAS entry
    stuck = 1'b1;
    clear_hist();
    pulse_start();
    wait_valid(3000, ok);
    chk("tmo_valid", 32'(ok), 32'd1);
    chk("tmo_latency", 32'(cyc - (first_ptat_cyc + 1)), 32'd1000);
    chk("tmo_err", 32'(res_err), 32'd1);
    chk("tmo_ptat", 32'(ptat_sum), 32'd0);
    chk("tmo_ctat", 32'(ctat_sum), 32'd0);
    handshake(hs);
    stuck = 1'b0;

    // sensor never leaves WARMUP: timeout 1000 cycles after WARM entry
    warm_len = 5000;
    pulse_start();
    wait_rst_low(20, e, ok);
    chk("warm_rst_low", 32'(ok), 32'd1);
    wait_valid(2000, ok);
    chk("warm_tmo_latency", 32'(cyc - e), 32'd1000);
    chk("warm_tmo_err", 32'(res_err), 32'd1);
    handshake(hs);
    warm_len = 8;

    // periodic: result held while not accepted, SRST 100 cycles after handshake
    clear_hist();
    period = 16'd100; per_en = 1'b1;
    wait_valid(5000, ok);
    chk("per_valid", 32'(ok), 32'd1);
    p0 = ptat_sum; c0 = ctat_sum; err0 = res_err;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || ptat_sum !== p0 || ctat_sum !== c0 || res_err !== err0) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    chk("hold_ptat", 32'(p0), 32'(NP * 40));
    chk("hold_ctat", 32'(c0), 32'(NP * 60));
    handshake(hs);
    clear_hist();
    wait_rst_low(300, e, ok);
    chk("per_restart", 32'(ok), 32'd1);
    chk("per_wait_len", 32'(e - hs), 32'd102);
    per_en = 1'b0;
    wait_valid(5000, ok);
    chk("noabort_valid", 32'(ok), 32'd1);
    check_model("noabort");
    handshake(hs);
    chk("noabort_idle", 32'(busy), 32'd0);

    // per_en dropped during WAIT returns to IDLE on the next cycle
    clear_hist();
    per_en = 1'b1;
    wait_valid(5000, ok);
    handshake(hs);
    repeat (10) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    per_en = 1'b0;
    @(negedge clk);
    chk("wait_abort", 32'(busy), 32'd0);
    repeat (150) @(negedge clk);
    chk("wait_abort_stay", 32'(busy), 32'd0);

    // period 0: WAIT lasts a single cycle
    clear_hist();
    period = 16'd0; per_en = 1'b1;
    wait_valid(5000, ok);
    handshake(hs);
    clear_hist();
    wait_rst_low(20, e, ok);
    chk("per0_wait_len", 32'(e - hs), 32'd3);
    per_en = 1'b0;
    wait_valid(5000, ok);
    check_model("per0");
    handshake(hs);

    // reset mid-measurement discards everything
    clear_hist();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((NP > 1) ? (ctat_sum === 10'(2 * 60)) : (ptat_sum !== 10'd0)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_reached", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sensor_rst", 32'(sensor_rst), 32'd1);
    chk("midrst_ptat", 32'(ptat_sum), 32'd0);
    chk("midrst_ctat", 32'(ctat_sum), 32'd0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("midrst_no_result", 32'(bad), 32'd0);

    // start pulses while busy are ignored
    clear_hist();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    wait_valid(5000, ok);
    pulse_start();
    chk("busy_start_valid", 32'(res_valid), 32'd1);
    check_model("busy_start");
    handshake(hs);
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("single_result", 32'(bad), 32'd0);

    // randomized phase lengths against the recorded-history model
    rand_len = 1'b1;
    for (int i = 0; i < 6; i++) begin
      warm_len = int'($urandom_range(1, 30));
      clear_hist();
      pulse_start();
      wait_valid(8000, ok);
      chk("rand_valid", 32'(ok), 32'd1);
      check_model("rand");
      handshake(hs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/temp_seq.md
TEMP_SEQ -- requirements
Module: temp_seq

Interface
REQ-001 SHALL have parameter N_AVG_LOG2, default 2, meaning log2 of PTAT/CTAT sample pairs accumulated per result.
REQ-002 SHALL have parameter PERIOD_W, default 16, meaning the width of the period register.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, meaning the maximum cycles allowed for any single sensor phase.
REQ-004 SHALL have these ports, in this order:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-shot request, 1-cycle pulse.
- per_en  in  1  enables periodic measurement.
- period  in  PERIOD_W  idle cycles between periodic measurements.
- sensor_state  in  2  state from the sensor controller: 0=WARMUP, 1=PTAT, 3=CTAT.
- sensor_count  in  8  cycle count from the sensor controller.
- sensor_rst  out  1  reset to the sensor controller.
- busy  out  1  high when not IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  result accepted.
- ptat_sum  out  8+N_AVG_LOG2  accumulated PTAT counts.
- ctat_sum  out  8+N_AVG_LOG2  accumulated CTAT counts.
- res_err  out  1  measurement timed out.

Function
REQ-005 SHALL implement these states: IDLE, SRST, WARM, MEAS, DONE, WAIT.
REQ-006 IDLE SHALL hold sensor_rst=1; on start=1 or per_en=1 it SHALL go to SRST.
REQ-007 SRST SHALL hold sensor_rst=1 for exactly 2 cycles, then go to WARM with sensor_rst=0.
REQ-008 WARM SHALL go to MEAS when sensor_state==1.
REQ-009 sensor_state and sensor_count SHALL be registered every cycle as st_q and cnt_q.
- A PTAT sample SHALL be captured as cnt_q when st_q==1 and sensor_state==3.
- A CTAT sample SHALL be captured as cnt_q when st_q==3 and sensor_state==1.
REQ-010 In MEAS, samples SHALL be zero-extended and added to ptat_sum or ctat_sum respectively; accumulation SHALL NOT wrap (width 8+N_AVG_LOG2 is sufficient).
REQ-011 A pair is complete on its CTAT capture; after 2^N_AVG_LOG2 pairs the block SHALL go to DONE with res_err=0.
REQ-012 A per-phase cycle counter SHALL clear on every capture and on MEAS/WARM entry. If it reaches TIMEOUT_CYC in WARM or MEAS, the block SHALL go to DONE with res_err=1 and the sums holding their partial values.
REQ-013 DONE SHALL assert res_valid and sensor_rst=1, and hold ptat_sum, ctat_sum and res_err stable until res_valid&&res_ready.
REQ-014 On handshake, DONE SHALL go to WAIT if per_en=1, else to IDLE.
REQ-015 WAIT SHALL count period cycles, then go to SRST; if per_en drops during WAIT, it SHALL go to IDLE next cycle.
REQ-016 period==0 SHALL make WAIT last 1 cycle.
REQ-017 start SHALL be ignored when busy=1.
REQ-018 Sums and the pair counter SHALL clear on SRST entry, not on DONE exit.
REQ-019 per_en dropping during WARM or MEAS SHALL NOT abort the measurement in progress.

Reset
REQ-020 On reset the block SHALL enter IDLE next edge with sensor_rst=1, busy=0, res_valid=0, res_err=0, ptat_sum=0, ctat_sum=0, all counters 0, st_q=0 and cnt_q=0.
REQ-021 Reset in any state, including DONE with res_valid pending, SHALL discard the result.

Configuration
REQ-022 The macro TEMP_SEQ_AVG_EN SHALL control averaging:
- Defined: 2^N_AVG_LOG2 pairs are accumulated.
- Undefined: exactly 1 pair is captured; the upper N_AVG_LOG2 bits of the sums read 0; port widths are unchanged.

Structure
REQ-023 Package temp_pkg SHALL hold the sensor state codes (WARMUP=0, PTAT=1, CTAT=3) and the sequencer state enum.
REQ-024 Sub-module temp_seq_capture SHALL contain st_q/cnt_q registration and PTAT/CTAT capture strobe generation.

Verification
REQ-025 Sensor model with PTAT=40 and CTAT=60 cycles, start pulse, AVG_EN with N_AVG_LOG2=2 -> ptat_sum=160, ctat_sum=240, res_err=0.
REQ-026 Same stimulus without TEMP_SEQ_AVG_EN -> ptat_sum=40, ctat_sum=60.
REQ-027 Sensor stuck in PTAT, TIMEOUT_CYC=1000 -> res_valid with res_err=1 exactly 1000 cycles after MEAS entry.
REQ-028 per_en=1, period=100, res_ready held 0 for 20 cycles -> result held stable; SRST asserted 100 cycles after handshake.
REQ-029 Reset asserted mid-MEAS after 2 pairs -> IDLE, sums=0, sensor_rst=1, no res_valid.
REQ-030 start pulsed while busy -> ignored; exactly one result produced.
